// File: rtl/muldiv_pkg.sv
// Shared types, constants and sign fix-up helper for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN     = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // hi/lo hold the unsigned product, or remainder/quotient for divides.
  function automatic logic [XLEN-1:0] fix_sign(input logic [2:0] f3, input logic neg,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg ? -{hi, lo} : {hi, lo};
    quo  = neg ? -lo : lo;
    rem  = neg ? -hi : hi;
    case (f3)
      F3_MUL:                       fix_sign = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_sign = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_sign = quo;
      default:                      fix_sign = rem;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One unsigned shift-add (multiply) or restoring shift-subtract (divide) step per enable.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            enable,
  input  logic            is_div,
  input  logic [XLEN-1:0] load_a,
  input  logic [XLEN-1:0] load_b,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next,
  output logic            last_iter
);

  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  addend;
  logic [XLEN:0]    sum, rem_shift, diff;

  // lo starts as multiplier/dividend and fills with product-low/quotient bits.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    addend    = lo_q[0] ? b_q : '0;
    sum       = {1'b0, hi_q} + {1'b0, addend};
    rem_shift = {hi_q, lo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, b_q};
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      hi_d  = '0;
      lo_d  = load_a;
      b_d   = load_b;
      cnt_d = '0;
    end else if (enable) begin
      if (is_div) begin
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = rem_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign hi_next   = hi_d;
  assign lo_next   = lo_d;
  assign last_iter = (cnt_q == CNT_W'(ITER_CNT - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit with valid/ready handshakes.
// Define FAST_MUL_EN to complete multiplies in one cycle with a combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            div_op, signed_a, signed_b, a_neg, b_neg, neg_op;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic            special;
  logic            core_load, core_en, core_clear, last_iter;
  logic [XLEN-1:0] hi_next, lo_next;

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

  // Core works on magnitudes; neg_op records whether the final value must be negated.
  always_comb begin
    div_op   = funct3[2];
    signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    signed_b = signed_a && (funct3 != F3_MULHSU);
    a_neg    = signed_a && operand1[XLEN-1];
    b_neg    = signed_b && operand2[XLEN-1];
    abs_a    = a_neg ? -operand1 : operand1;
    abs_b    = b_neg ? -operand2 : operand2;
    neg_op   = (div_op && funct3[1]) ? a_neg : (a_neg ^ b_neg);

    special     = 1'b0;
    special_res = '0;
    if (div_op && (operand2 == '0)) begin
      special     = 1'b1;
      special_res = funct3[1] ? operand1 : '1;
    end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1)) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : operand1;
    end
`ifdef FAST_MUL_EN
    else if (!div_op) begin
      special     = 1'b1;
      special_res = fix_sign(funct3, neg_op, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    neg_d      = neg_q;
    result_d   = result_q;
    core_load  = 1'b0;
    core_en    = 1'b0;
    core_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          funct3_d = funct3;
          neg_d    = neg_op;
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            core_load = 1'b1;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        core_en = 1'b1;
        if (last_iter) begin
          result_d = fix_sign(funct3_q, neg_q, hi_next, lo_next);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A killed operation never updates the result, even on its final step.
    if (flush) begin
      state_d    = ST_IDLE;
      funct3_d   = funct3_q;
      neg_d      = neg_q;
      result_d   = result_q;
      core_load  = 1'b0;
      core_en    = 1'b0;
      core_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  muldiv_iter_core u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (core_clear),
    .load      (core_load),
    .enable    (core_en),
    .is_div    (funct3_q[2]),
    .load_a    (div_op ? abs_a : abs_b),
    .load_b    (div_op ? abs_b : abs_a),
    .hi_next   (hi_next),
    .lo_next   (lo_next),
    .last_iter (last_iter)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] operand1, operand2, result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9] = '{
    '{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
    '{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
    '{DIVU,   32'd100,      32'h00000000, 32'hFFFFFFFF},
    '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000},
    '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{MULH,   32'h80000000, 32'h80000000, 32'h40000000},
    '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE}
  };

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    case (f3)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV:    begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      DIVU:   begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == DIV || f3 == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3   = f3;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    operand1 = $urandom;
    operand2 = $urandom;
  endtask

  // Waits (bounded) for out_valid while throwing ignored traffic at the inputs.
  task automatic wait_result(output logic [31:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid  = 1'($urandom);
      funct3    = 3'($urandom);
      operand1  = $urandom;
      operand2  = $urandom;
      out_ready = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    res      = result;
  endtask

  task automatic complete();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (result !== 32'h0)   begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int          lat;
    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_result(res, lat);
      checks += 2;
      if (res !== vecs[i].exp) begin
        errors++;
        $display("[TB] FAIL directed_%0d_result: got %h expected %h", i, res, vecs[i].exp);
      end
      if (lat != exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b)) begin
        errors++;
        $display("[TB] FAIL directed_%0d_latency: got %0d expected %0d", i, lat, exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b));
      end
      complete();
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom);
      a  = rand_operand();
      b  = rand_operand();
      issue(f3, a, b);
      wait_result(res, lat);
      checks += 2;
      if (res !== model(f3, a, b)) begin
        errors++;
        $display("[TB] FAIL random_%0d_result f3=%0d a=%h b=%h: got %h expected %h", n, f3, a, b, res, model(f3, a, b));
      end
      if (lat != exp_lat(f3, a, b)) begin
        errors++;
        $display("[TB] FAIL random_%0d_latency: got %0d expected %0d", n, lat, exp_lat(f3, a, b));
      end
      complete();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL random_%0d_in_ready: got %b expected 1", n, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    issue(DIVU, 32'd10, 32'd3);
    wait_result(res, lat);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks += 3;
      if (out_valid !== 1'b1)    begin errors++; $display("[TB] FAIL hold_%0d_out_valid: got %b expected 1", k, out_valid); end
      if (result !== 32'h3)      begin errors++; $display("[TB] FAIL hold_%0d_result: got %h expected 00000003", k, result); end
      if (in_ready !== 1'b0)     begin errors++; $display("[TB] FAIL hold_%0d_in_ready: got %b expected 0", k, in_ready); end
    end
    complete();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_out_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL hold_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          lat;
    issue(DIV, 32'd1000, 32'd7);
    for (int k = 0; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks += 3;
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
    issue(DIVU, 32'd9, 32'd3);
    wait_result(res, lat);
    checks += 2;
    if (res !== 32'h3) begin errors++; $display("[TB] FAIL after_flush_result: got %h expected 00000003", res); end
    if (lat != 33)     begin errors++; $display("[TB] FAIL after_flush_latency: got %0d expected 33", lat); end
    complete();
  endtask

  task automatic test_rst_mid();
    issue(DIVU, 32'd12345, 32'd5);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    if (result !== 32'h0)   begin errors++; $display("[TB] FAIL rst_mid_result: got %h expected 00000000", result); end
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_flush_accept();
    logic [31:0] bs [2] = '{32'd3, 32'd0};
    int          seen;
    foreach (bs[i]) begin
      funct3   = DIVU;
      operand1 = 32'd9;
      operand2 = bs[i];
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      checks += 2;
      if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL flush_accept_%0d_busy: got %b expected 0", i, busy); end
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_accept_%0d_in_ready: got %b expected 1", i, in_ready); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (out_valid) seen++;
        tick();
      end
      checks++;
      if (seen != 0) begin errors++; $display("[TB] FAIL flush_accept_%0d_no_result: got %0d valid cycles expected 0", i, seen); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    funct3    = 3'b000;
    operand1  = 32'h0;
    operand2  = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_flush_accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
